// File: rtl/alu_serial_ctrl_if.sv
// Bit-level link between alu_serial_ctrl (master) and one 1-bit ALU slice (slave).
`default_nettype none

interface alu_serial_ctrl_if;
  logic       slice_a;
  logic       slice_b;
  logic [2:0] slice_op;
  logic       slice_cin;
  logic       slice_invert;
  logic       slice_less;
  logic       slice_salida;
  logic       slice_cout;
  logic       slice_set;

  modport master (
    output slice_a, slice_b, slice_op, slice_cin, slice_invert, slice_less,
    input  slice_salida, slice_cout, slice_set
  );

  modport slave (
    input  slice_a, slice_b, slice_op, slice_cin, slice_invert, slice_less,
    output slice_salida, slice_cout, slice_set
  );
endinterface

`default_nettype wire

// File: rtl/alu_serial_ctrl.sv
// ============================================================================
//  alu_serial_ctrl : bit-serial driver/collector for a single 1-bit ALU slice.
//  Optional: ALU_SLTU_EN adds unsigned set-less-than (funct 101011).
//  Rev 1.0
// ============================================================================
`default_nettype none

module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  wire logic             clk_i,
  input  wire logic             rst_ni,
  input  wire logic             start_i,
  input  wire logic [1:0]       alu_op_i,
  input  wire logic [5:0]       funct_i,
  input  wire logic [WIDTH-1:0] a_i,
  input  wire logic [WIDTH-1:0] b_i,
  alu_serial_ctrl_if.master     slice,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [WIDTH-1:0]      resultado_o,
  output logic                  zero_o,
  output logic                  illegal_o
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CALC    = 2'd1,
    S_SETLESS = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_res;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic             r_inv, r_carry, r_setless, r_bad, r_less;
  logic             r_zero, r_illegal;

  logic [2:0]       w_dec_op;
  logic             w_dec_inv, w_dec_cin, w_dec_setless, w_dec_bad;
  logic [WIDTH-1:0] w_acc_next, w_final;
  logic             w_last, w_less_bit;
`ifdef ALU_SLTU_EN
  logic             r_sltu, w_dec_sltu;
`endif

  always_comb begin
    w_dec_op      = 3'b111;
    w_dec_inv     = 1'b0;
    w_dec_cin     = 1'b0;
    w_dec_setless = 1'b0;
    w_dec_bad     = 1'b1;
`ifdef ALU_SLTU_EN
    w_dec_sltu    = 1'b0;
`endif
    unique case (alu_op_i)
      2'b00: begin w_dec_op = 3'b010; w_dec_bad = 1'b0; end
      2'b01: begin w_dec_op = 3'b010; w_dec_inv = 1'b1; w_dec_cin = 1'b1; w_dec_bad = 1'b0; end
      2'b10: begin
        unique case (funct_i)
          6'b100000: begin w_dec_op = 3'b010; w_dec_bad = 1'b0; end
          6'b100010: begin w_dec_op = 3'b010; w_dec_inv = 1'b1; w_dec_cin = 1'b1; w_dec_bad = 1'b0; end
          6'b100100: begin w_dec_op = 3'b000; w_dec_bad = 1'b0; end
          6'b100101: begin w_dec_op = 3'b001; w_dec_bad = 1'b0; end
          6'b100110: begin w_dec_op = 3'b011; w_dec_bad = 1'b0; end
          6'b101010: begin
            w_dec_op = 3'b010; w_dec_inv = 1'b1; w_dec_cin = 1'b1;
            w_dec_setless = 1'b1; w_dec_bad = 1'b0;
          end
`ifdef ALU_SLTU_EN
          6'b101011: begin
            w_dec_op = 3'b101; w_dec_inv = 1'b1; w_dec_cin = 1'b1;
            w_dec_setless = 1'b1; w_dec_sltu = 1'b1; w_dec_bad = 1'b0;
          end
`endif
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign w_last     = (r_cnt == C_LAST);
  assign w_acc_next = {slice.slice_salida, r_acc[WIDTH-1:1]};
  assign w_final    = r_bad ? '0 : w_acc_next;

  // Signed: sign of the difference corrected by overflow (carry-in ^ carry-out of the MSB).
`ifdef ALU_SLTU_EN
  assign w_less_bit = r_sltu ? slice.slice_set
                             : slice.slice_set ^ (r_carry ^ slice.slice_cout);
`else
  assign w_less_bit = slice.slice_set ^ (r_carry ^ slice.slice_cout);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_res     <= '0;
      r_cnt     <= '0;
      r_op      <= 3'b000;
      r_inv     <= 1'b0;
      r_carry   <= 1'b0;
      r_setless <= 1'b0;
      r_bad     <= 1'b0;
      r_less    <= 1'b0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
`ifdef ALU_SLTU_EN
      r_sltu    <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_a       <= a_i;
            r_b       <= b_i;
            r_op      <= w_dec_op;
            r_inv     <= w_dec_inv;
            r_carry   <= w_dec_cin;
            r_setless <= w_dec_setless;
            r_bad     <= w_dec_bad;
            r_cnt     <= '0;
`ifdef ALU_SLTU_EN
            r_sltu    <= w_dec_sltu;
`endif
          end
        end
        S_CALC: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_acc   <= w_acc_next;
          r_carry <= slice.slice_cout;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_cnt  <= '0;
            r_less <= w_less_bit;
            if (!r_setless) begin
              r_res     <= w_final;
              r_zero    <= (w_final == '0);
              r_illegal <= r_bad;
            end
          end
        end
        S_SETLESS: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_cnt     <= '0;
            r_res     <= w_final;
            r_zero    <= (w_final == '0);
            r_illegal <= r_bad;
          end
        end
        S_DONE: ;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next             = r_state;
    busy_o             = 1'b0;
    done_o             = 1'b0;
    slice.slice_a      = 1'b0;
    slice.slice_b      = 1'b0;
    slice.slice_op     = 3'b000;
    slice.slice_cin    = 1'b0;
    slice.slice_invert = 1'b0;
    slice.slice_less   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) w_next = S_CALC;
      end
      S_CALC: begin
        busy_o             = 1'b1;
        slice.slice_a      = r_a[0];
        slice.slice_b      = r_b[0];
        slice.slice_op     = r_op;
        slice.slice_cin    = r_carry;
        slice.slice_invert = r_inv;
        if (w_last) w_next = r_setless ? S_SETLESS : S_DONE;
      end
      S_SETLESS: begin
        busy_o           = 1'b1;
        slice.slice_op   = 3'b100;
        slice.slice_less = (r_cnt == '0) ? r_less : 1'b0;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done_o = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign resultado_o = r_res;
  assign zero_o      = r_zero;
  assign illegal_o   = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_serial_ctrl.sv
// ============================================================================
//  tb_alu_serial_ctrl : directed self-checking bench with a behavioural slice.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_serial_ctrl;
  localparam int WIDTH = 32;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             start_i = 1'b0;
  logic [1:0]       alu_op_i = 2'b00;
  logic [5:0]       funct_i = 6'd0;
  logic [WIDTH-1:0] a_i = '0;
  logic [WIDTH-1:0] b_i = '0;
  logic             busy_o, done_o, zero_o, illegal_o;
  logic [WIDTH-1:0] resultado_o;

  int n_checks = 0;
  int n_fail   = 0;

  alu_serial_ctrl_if sif ();

  alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .alu_op_i    (alu_op_i),
    .funct_i     (funct_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .slice       (sif),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .resultado_o (resultado_o),
    .zero_o      (zero_o),
    .illegal_o   (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference 1-bit slice; set is the sum bit, or ~carry-out for the unsigned compare op.
  logic m_bb, m_sum, m_cout, m_out;
  always_comb begin
    m_bb   = sif.slice_b ^ sif.slice_invert;
    m_sum  = sif.slice_a ^ m_bb ^ sif.slice_cin;
    m_cout = (sif.slice_a & m_bb) | (sif.slice_a & sif.slice_cin) | (m_bb & sif.slice_cin);
    m_out  = 1'b0;
    case (sif.slice_op)
      3'b000: m_out = sif.slice_a & m_bb;
      3'b001: m_out = sif.slice_a | m_bb;
      3'b010: m_out = m_sum;
      3'b011: m_out = sif.slice_a ^ m_bb;
      3'b100: m_out = sif.slice_less;
      3'b101: m_out = m_sum;
      default: m_out = 1'b0;
    endcase
  end
  assign sif.slice_salida = m_out;
  assign sif.slice_cout   = m_cout;
  assign sif.slice_set    = (sif.slice_op == 3'b101) ? ~m_cout : m_sum;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input logic exp_z, input logic exp_i,
                        input int exp_lat, input bit hold);
    int cyc;
    int ndone;
    @(negedge clk_i);
    start_i = 1'b1; alu_op_i = op; funct_i = fn; a_i = a; b_i = b;
    @(posedge clk_i);
    @(negedge clk_i);
    if (!hold) start_i = 1'b0;
    cyc = 1;
    ndone = 0;
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
    while (!done_o && cyc < 200) begin
      @(posedge clk_i);
      @(negedge clk_i);
      cyc++;
    end
    start_i = 1'b0;
    if (done_o) ndone = 1;
    if (exp_lat != 0) check({tag, "_latency"}, cyc, exp_lat);
    else              check({tag, "_done_seen"}, {31'd0, done_o}, 32'd1);
    check({tag, "_result"},  resultado_o, exp_r);
    check({tag, "_zero"},    {31'd0, zero_o}, {31'd0, exp_z});
    check({tag, "_illegal"}, {31'd0, illegal_o}, {31'd0, exp_i});
    repeat (3) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (done_o) ndone++;
    end
    check({tag, "_idle_after"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_one_done"}, ndone, 1);
    check({tag, "_held_result"}, resultado_o, exp_r);
  endtask

  initial begin
    int cyc;
    repeat (2) @(negedge clk_i);
    check("rst_busy",     {31'd0, busy_o}, 32'd0);
    check("rst_done",     {31'd0, done_o}, 32'd0);
    check("rst_result",   resultado_o, 32'd0);
    check("rst_zero",     {31'd0, zero_o}, 32'd0);
    check("rst_illegal",  {31'd0, illegal_o}, 32'd0);
    check("rst_slice_op", {29'd0, sif.slice_op}, 32'd0);
    rst_ni = 1'b1;

    run_op("add",      2'b00, 6'd0,      32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0, 33, 1'b0);
    run_op("sub_wrap", 2'b01, 6'd0,      32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0, 33, 1'b0);
    run_op("sub_eq",   2'b01, 6'd0,      32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 33, 1'b0);
    run_op("and",      2'b10, 6'b100100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 33, 1'b0);
    run_op("or",       2'b10, 6'b100101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, 33, 1'b0);
    run_op("xor",      2'b10, 6'b100110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0, 33, 1'b0);
    run_op("f_sub",    2'b10, 6'b100010, 32'h0000_0010, 32'h0000_0001, 32'h0000_000F, 1'b0, 1'b0, 33, 1'b0);
    run_op("slt_ovf",  2'b10, 6'b101010, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 65, 1'b0);
    run_op("slt_swap", 2'b10, 6'b101010, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 65, 1'b0);
    run_op("illegal",  2'b11, 6'd0,      32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b1, 0,  1'b0);
    run_op("bad_fn",   2'b10, 6'b000111, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b1, 0,  1'b0);
`ifdef ALU_SLTU_EN
    run_op("sltu",     2'b10, 6'b101011, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 65, 1'b0);
    run_op("sltu_lt",  2'b10, 6'b101011, 32'h0000_0001, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 65, 1'b0);
`else
    run_op("sltu_off", 2'b10, 6'b101011, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 0,  1'b0);
`endif
    run_op("hold_add", 2'b10, 6'b100000, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0, 1'b0, 33, 1'b1);

    // Abort an add on its 10th cycle; nothing may complete afterwards.
    @(negedge clk_i);
    start_i = 1'b1; alu_op_i = 2'b00; a_i = 32'h0000_0100; b_i = 32'h0000_0023;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (9) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_busy",     {31'd0, busy_o}, 32'd0);
    check("mid_rst_result",   resultado_o, 32'd0);
    check("mid_rst_slice_op", {29'd0, sif.slice_op}, 32'd0);
    check("mid_rst_slice_a",  {31'd0, sif.slice_a}, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    cyc = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (done_o) cyc++;
    end
    check("mid_rst_no_done", cyc, 0);
    run_op("post_rst", 2'b00, 6'd0, 32'h0000_0100, 32'h0000_0023, 32'h0000_0123, 1'b0, 1'b0, 33, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
